sig_check_engine: RTL and testbench
===================================

// Module: sig_check_engine
// PURPOSE
//  Synthesizable successor to the sim-only arch-test signature check. Snoops core data-bus stores
//  for the begin/end signature pointers, walks the signature region over a RAM read port and
//  compares each word against a golden ROM port. Reports done/pass, mismatch count, first failing
//  word and timeout. Sits in minisoc beside the memory, for FPGA-hosted compliance runs.
// PARAMETERS
//  AW         22          byte-address width of bus/RAM
//  GOLD_AW    10          golden ROM word-address width (depth 1<<GOLD_AW)
//  BEGIN_PTR  'h3FF0      byte address of begin-signature pointer word
//  END_PTR    'h3FF4      byte address of end-signature pointer word
//  MIN_BEGIN  16          begin pointer must exceed this to arm
//  TIMEOUT    40000       cycles to timeout (used only with SIG_CHECK_TIMEOUT_EN)
// PORTS
//  clk          in   1        clock
//  rst_b        in   1        async active-low reset
//  st_valid     in   1        core store accepted this cycle (snoop only, never stalls)
//  st_addr      in   AW       store byte address (word aligned)
//  st_wdata     in   32       store data
//  ram_rd       out  1        RAM read request
//  ram_addr     out  AW       RAM byte address
//  ram_rdata    in   32       RAM data, valid exactly 1 cycle after ram_rd
//  gold_addr    out  GOLD_AW  golden word index
//  gold_rdata   in   32       golden data, valid 1 cycle after ram_rd (same timing as RAM)
//  done         out  1        sticky: check finished (pass, fail or timeout)
//  pass         out  1        sticky: valid when done; 1 = all words match
//  mismatch_cnt out  16       mismatching words, saturates at 16'hFFFF
//  fail_idx     out  GOLD_AW  word offset of first mismatch
//  overflow     out  1        region larger than golden depth
//  timeout      out  1        sticky timeout flag
// BEHAVIOUR
//  Reset: all outputs 0; begin_q/end_q 0; state IDLE.
//  Snoop: st_valid && st_addr==BEGIN_PTR -> begin_q<=st_wdata; same for END_PTR -> end_q.
//   Snoop active in every state; pointer writes after leaving IDLE are ignored for this run.
//  FSM IDLE -> ARM when end_q>begin_q && begin_q>MIN_BEGIN (registered compare, 1 cycle).
//   ARM: nwords=(end_q-begin_q)>>2; nwords > 1<<GOLD_AW -> overflow=1, pass=0, DONE.
//   else ptr=begin_q, off=0 -> READ.
//   READ: ram_rd=1, ram_addr=ptr, gold_addr=off -> CMP.
//   CMP: ram_rdata!=gold_rdata -> mismatch_cnt++ (sat); first mismatch latches fail_idx=off.
//    off+1==nwords -> DONE, else ptr+=4, off++ -> READ. 2 cycles per word.
//  DONE: done=1, pass=(mismatch_cnt==0 && !overflow && !timeout). Held until reset.
//  Region is [begin_q, end_q); end_q-begin_q not multiple of 4 -> low bits dropped.
//  ram_rd is single-cycle per word; no back-to-back reads.
//  Async reset mid-walk aborts immediately; no partial results kept.
// CONFIGURATION
//  SIG_CHECK_TIMEOUT_EN defined: free-running cycle counter from reset release; reaching TIMEOUT
//   in any state but DONE -> timeout=1, pass=0, DONE.
//   If reached in the same cycle CMP would finish, timeout wins.
//  Undefined: no counter, timeout tied 0, engine waits in IDLE indefinitely.
// STRUCTURE
//  sig_check_pkg: state_e enum {IDLE,ARM,READ,CMP,DONE}, default pointer-address constants.
//  One sub-module natural: sig_ptr_snoop (pointer capture regs + arm compare).
//  Walk FSM and counters stay in the top.
// TESTING
//  1 Store begin='h2000, end='h2010; RAM and golden match -> done after ARM+8 cycles, pass=1, cnt=0.
//  2 Same region, word 2 corrupted -> pass=0, mismatch_cnt=1, fail_idx=2.
//  3 begin=8, end='h100 -> stays IDLE (not armed); done=0.
//  4 begin='h2000, end='h2000+4*1025 with GOLD_AW=10 -> overflow=1, pass=0, done=1.
//  5 TIMEOUT_EN, TIMEOUT=100, no pointer stores -> timeout=1, done=1 at cycle 100.
//  6 Assert rst_b low during READ of word 3 -> all outputs 0 next edge; rerun passes.

Source files
------------

// File: rtl/sig_check_pkg.sv
// Shared types and default constants for the signature check engine.
package sig_check_pkg;

  // Walk FSM states.
  typedef enum logic [2:0] {
    IDLE,
    ARM,
    READ,
    CMP,
    DONE
  } state_e;

  // Default byte addresses of the begin/end signature pointer words.
  localparam logic [31:0] DEF_BEGIN_PTR = 32'h0000_3FF0;
  localparam logic [31:0] DEF_END_PTR   = 32'h0000_3FF4;

  // Smallest begin pointer that is still considered a real signature region.
  localparam int DEF_MIN_BEGIN = 16;

  // Default timeout in cycles (only meaningful when the timeout feature is built in).
  localparam int DEF_TIMEOUT = 40000;

  // Saturating 16-bit increment for the mismatch counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sig_ptr_snoop.sv
// Captures the begin/end signature pointers from core stores and produces
// a registered "region looks valid" flag for the walk FSM.
module sig_ptr_snoop
  import sig_check_pkg::*;
#(
  parameter int          AW        = 22,
  parameter logic [31:0] BEGIN_PTR = DEF_BEGIN_PTR,
  parameter logic [31:0] END_PTR   = DEF_END_PTR,
  parameter int          MIN_BEGIN = DEF_MIN_BEGIN
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          st_valid,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_wdata,
  output logic [31:0]   begin_q,
  output logic [31:0]   end_q,
  output logic          arm_ok
);

  localparam logic [31:0] MIN_BEGIN_W = 32'(MIN_BEGIN);

  // Pointer capture: the last store to each pointer word wins.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      begin_q <= '0;
      end_q   <= '0;
    end else if (st_valid) begin
      if (st_addr == BEGIN_PTR[AW-1:0]) begin_q <= st_wdata;
      if (st_addr == END_PTR[AW-1:0])   end_q   <= st_wdata;
    end
  end

  // Registered arm compare keeps the wide comparators off the FSM path.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) arm_ok <= 1'b0;
    else        arm_ok <= (end_q > begin_q) && (begin_q > MIN_BEGIN_W);
  end

endmodule

// File: rtl/sig_check_engine.sv
// Signature check engine: snoops the signature pointers, walks the region over
// a RAM read port and compares each word against a golden ROM port.
// Optional build macro: SIG_CHECK_TIMEOUT_EN adds a cycle-count timeout.
module sig_check_engine
  import sig_check_pkg::*;
#(
  parameter int          AW        = 22,
  parameter int          GOLD_AW   = 10,
  parameter logic [31:0] BEGIN_PTR = DEF_BEGIN_PTR,
  parameter logic [31:0] END_PTR   = DEF_END_PTR,
  parameter int          MIN_BEGIN = DEF_MIN_BEGIN,
  parameter int          TIMEOUT   = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               st_valid,
  input  logic [AW-1:0]      st_addr,
  input  logic [31:0]        st_wdata,
  output logic               ram_rd,
  output logic [AW-1:0]      ram_addr,
  input  logic [31:0]        ram_rdata,
  output logic [GOLD_AW-1:0] gold_addr,
  input  logic [31:0]        gold_rdata,
  output logic               done,
  output logic               pass,
  output logic [15:0]        mismatch_cnt,
  output logic [GOLD_AW-1:0] fail_idx,
  output logic               overflow,
  output logic               timeout
);

  localparam int          NW_W      = GOLD_AW + 1;
  localparam logic [31:0] MAX_WORDS = 32'(1) << GOLD_AW;

  logic [31:0] begin_q, end_q;
  logic        arm_ok;

  sig_ptr_snoop #(
    .AW        (AW),
    .BEGIN_PTR (BEGIN_PTR),
    .END_PTR   (END_PTR),
    .MIN_BEGIN (MIN_BEGIN)
  ) u_snoop (
    .clk      (clk),
    .rst_b    (rst_b),
    .st_valid (st_valid),
    .st_addr  (st_addr),
    .st_wdata (st_wdata),
    .begin_q  (begin_q),
    .end_q    (end_q),
    .arm_ok   (arm_ok)
  );

  state_e             state_q, state_d;
  logic [AW-1:0]      ptr_q, ptr_d;
  logic [GOLD_AW-1:0] off_q, off_d;
  logic [NW_W-1:0]    nwords_q, nwords_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [GOLD_AW-1:0] fail_idx_q, fail_idx_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               overflow_q, overflow_d;
  logic               timeout_q, timeout_d;
  logic               to_hit;

  // Region size in words; the two low address bits of the difference are dropped.
  logic [31:0]     diff;
  logic [31:0]     nwords_full;
  logic [NW_W-1:0] off_next;

  assign diff        = end_q - begin_q;
  assign nwords_full = diff >> 2;
  assign off_next    = NW_W'(off_q) + NW_W'(1);

`ifdef SIG_CHECK_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);
  logic [31:0] to_cnt_q;

  // Free-running cycle count since reset release; parks once the limit is reached.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)                 to_cnt_q <= '0;
    else if (to_cnt_q != TO_LAST) to_cnt_q <= to_cnt_q + 32'd1;
  end

  assign to_hit = (to_cnt_q == TO_LAST);
`else
  assign to_hit = 1'b0;
`endif

  // Walk FSM next-state and result bookkeeping.
  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    off_d      = off_q;
    nwords_d   = nwords_q;
    cnt_d      = cnt_q;
    fail_idx_d = fail_idx_q;
    done_d     = done_q;
    pass_d     = pass_q;
    overflow_d = overflow_q;
    timeout_d  = timeout_q;

    case (state_q)
      IDLE: if (arm_ok) state_d = ARM;

      ARM: begin
        if (nwords_full > MAX_WORDS) begin
          overflow_d = 1'b1;
          pass_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = DONE;
        end else if (nwords_full == '0) begin
          // Sub-word region: nothing to compare, nothing mismatched.
          pass_d  = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          ptr_d    = begin_q[AW-1:0];
          off_d    = '0;
          nwords_d = nwords_full[NW_W-1:0];
          state_d  = READ;
        end
      end

      READ: state_d = CMP;

      CMP: begin
        if (ram_rdata != gold_rdata) begin
          // The counter never returns to zero, so zero means "first mismatch".
          if (cnt_q == '0) fail_idx_d = off_q;
          cnt_d = sat_inc16(cnt_q);
        end
        if (off_next == nwords_q) begin
          done_d  = 1'b1;
          pass_d  = (cnt_d == '0);
          state_d = DONE;
        end else begin
          ptr_d   = ptr_q + AW'(4);
          off_d   = off_q + GOLD_AW'(1);
          state_d = READ;
        end
      end

      DONE: state_d = DONE;

      default: state_d = IDLE;
    endcase

    // Timeout overrides any other outcome, including a walk finishing this cycle.
    if (to_hit && state_q != DONE) begin
      timeout_d = 1'b1;
      pass_d    = 1'b0;
      done_d    = 1'b1;
      state_d   = DONE;
    end
  end

  // State and result registers; reset discards any partial walk.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      off_q      <= '0;
      nwords_q   <= '0;
      cnt_q      <= '0;
      fail_idx_q <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      off_q      <= off_d;
      nwords_q   <= nwords_d;
      cnt_q      <= cnt_d;
      fail_idx_q <= fail_idx_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
    end
  end

  assign ram_rd       = (state_q == READ);
  assign ram_addr     = ptr_q;
  assign gold_addr    = off_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign mismatch_cnt = cnt_q;
  assign fail_idx     = fail_idx_q;
  assign overflow     = overflow_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_sig_check_engine.sv
// Self-checking bench for sig_check_engine: directed scenarios plus randomized
// regions, checked against a word-by-word reference comparison of the memories.
// Build with SIG_CHECK_TIMEOUT_EN to exercise the timeout path.
module tb_sig_check_engine;

  localparam int AW      = 22;
  localparam int GOLD_AW = 10;
`ifdef SIG_CHECK_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 40000;
`endif
  localparam logic [AW-1:0] BEGIN_A = AW'(32'h3FF0);
  localparam logic [AW-1:0] END_A   = AW'(32'h3FF4);

  logic               clk = 1'b0;
  logic               rst_b = 1'b0;
  logic               st_valid = 1'b0;
  logic [AW-1:0]      st_addr = '0;
  logic [31:0]        st_wdata = '0;
  logic               ram_rd;
  logic [AW-1:0]      ram_addr;
  logic [31:0]        ram_rdata = '0;
  logic [GOLD_AW-1:0] gold_addr;
  logic [31:0]        gold_rdata = '0;
  logic               done, pass, overflow, timeout;
  logic [15:0]        mismatch_cnt;
  logic [GOLD_AW-1:0] fail_idx;

  sig_check_engine #(.AW(AW), .GOLD_AW(GOLD_AW), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .st_valid     (st_valid),
    .st_addr      (st_addr),
    .st_wdata     (st_wdata),
    .ram_rd       (ram_rd),
    .ram_addr     (ram_addr),
    .ram_rdata    (ram_rdata),
    .gold_addr    (gold_addr),
    .gold_rdata   (gold_rdata),
    .done         (done),
    .pass         (pass),
    .mismatch_cnt (mismatch_cnt),
    .fail_idx     (fail_idx),
    .overflow     (overflow),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  // Memory models: 16 KB of RAM and the full golden ROM.
  logic [31:0] ram_mem  [0:4095];
  logic [31:0] gold_mem [0:1023];

  // One-cycle read latency; garbage on the buses whenever no read was issued.
  always @(posedge clk) begin
    if (ram_rd) begin
      ram_rdata  <= ram_mem[ram_addr[13:2]];
      gold_rdata <= gold_mem[gold_addr];
    end else begin
      ram_rdata  <= $urandom;
      gold_rdata <= $urandom;
    end
  end

  // Read-port monitor: counts reads, flags back-to-back reads and wrong addresses.
  int   rd_total = 0, rd_base = 0, b2b_err = 0, addr_err = 0;
  int   exp_base = 0;
  logic prev_rd = 1'b0;
  always @(negedge clk) begin
    if (ram_rd) begin
      if (prev_rd) b2b_err++;
      if (ram_addr !== AW'(exp_base + 4 * (rd_total - rd_base)) ||
          gold_addr !== GOLD_AW'(rd_total - rd_base))
        addr_err++;
      rd_total++;
    end
    prev_rd = ram_rd;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    st_valid = 1'b1;
    st_addr  = a;
    st_wdata = d;
    @(negedge clk);
    st_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_b    = 1'b0;
    st_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
  endtask

  // Waits (bounded) for done; k is the number of rising edges seen.
  task automatic wait_done(input int bound, output int k);
    k = 0;
    while (k < bound && done !== 1'b1) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  // Fresh random memories; region of n words at byte address b matches golden.
  task automatic fill(input int b, input int n);
    for (int i = 0; i < 4096; i++) ram_mem[i] = $urandom;
    for (int i = 0; i < 1024; i++) gold_mem[i] = $urandom;
    for (int i = 0; i < n; i++) ram_mem[b / 4 + i] = gold_mem[i];
  endtask

  task automatic corrupt(input int b, input int i);
    ram_mem[b / 4 + i] = ram_mem[b / 4 + i] ^ (32'($urandom) | 32'h1);
  endtask

  // Reference: compare the region word by word.
  task automatic model(input int b, input int n, output int cnt, output int idx);
    cnt = 0;
    idx = 0;
    for (int i = 0; i < n; i++)
      if (ram_mem[b / 4 + i] != gold_mem[i]) begin
        if (cnt == 0) idx = i;
        cnt++;
      end
  endtask

  // Program the pointers for an n-word region and check the full outcome.
  task automatic run_walk(input string tag, input int b, input int n, input int tail);
    int ecnt, eidx, k, b2b0, addr0;
    model(b, n, ecnt, eidx);
    rd_base  = rd_total;
    exp_base = b;
    b2b0     = b2b_err;
    addr0    = addr_err;
    store(BEGIN_A, 32'(b));
    store(END_A, 32'(b + 4 * n + tail));
    wait_done(3 + 2 * n + 20, k);
    check({tag, "/latency"},  64'(k),              64'(3 + 2 * n));
    check({tag, "/done"},     64'(done),           64'(1));
    check({tag, "/pass"},     64'(pass),           64'(ecnt == 0));
    check({tag, "/cnt"},      64'(mismatch_cnt),   64'(ecnt));
    check({tag, "/fail_idx"}, 64'(fail_idx),       64'(eidx));
    check({tag, "/overflow"}, 64'(overflow),       64'(0));
    check({tag, "/timeout"},  64'(timeout),        64'(0));
    check({tag, "/reads"},    64'(rd_total - rd_base), 64'(n));
    check({tag, "/b2b"},      64'(b2b_err - b2b0), 64'(0));
    check({tag, "/addr"},     64'(addr_err - addr0), 64'(0));
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({done, pass, mismatch_cnt, fail_idx, overflow, timeout, ram_rd, ram_addr, gold_addr});
  endfunction

  initial begin
    int k, n, b, r0;

    // Reset state.
    #1;
    check("reset/outputs", all_outs(), 64'(0));
    repeat (2) @(negedge clk);
    rst_b = 1'b1;

`ifdef SIG_CHECK_TIMEOUT_EN
    // No pointers ever stored: timeout fires at cycle TO.
    do_reset();
    wait_done(2 * TO, k);
    check("timeout/cycle", 64'(k),       64'(TO));
    check("timeout/flag",  64'(timeout), 64'(1));
    check("timeout/done",  64'(done),    64'(1));
    check("timeout/pass",  64'(pass),    64'(0));
`endif

    // Begin pointer not above the minimum: engine must not arm.
    do_reset();
    r0 = rd_total;
    store(BEGIN_A, 32'd8);
    store(END_A, 32'h100);
    repeat (30) @(negedge clk);
    store(BEGIN_A, 32'd16);
    repeat (30) @(negedge clk);
    check("noarm/done",    64'(done),           64'(0));
    check("noarm/reads",   64'(rd_total - r0),  64'(0));
    check("noarm/timeout", 64'(timeout),        64'(0));

    // Clean 4-word region.
    do_reset();
    fill(32'h2000, 4);
    run_walk("match4", 32'h2000, 4, 0);

    // Word 2 corrupted.
    do_reset();
    fill(32'h2000, 4);
    corrupt(32'h2000, 2);
    run_walk("bad2", 32'h2000, 4, 0);
    check("bad2/idx_const", 64'(fail_idx),     64'(2));
    check("bad2/cnt_const", 64'(mismatch_cnt), 64'(1));

    // Region one word larger than the golden ROM.
    do_reset();
    r0 = rd_total;
    store(BEGIN_A, 32'h2000);
    store(END_A, 32'h2000 + 4 * 1025);
    wait_done(30, k);
    check("ovf/latency",  64'(k),              64'(3));
    check("ovf/overflow", 64'(overflow),       64'(1));
    check("ovf/done",     64'(done),           64'(1));
    check("ovf/pass",     64'(pass),           64'(0));
    check("ovf/reads",    64'(rd_total - r0),  64'(0));

    // Reset in the READ cycle of word 3 aborts the walk; a rerun still passes.
    do_reset();
    fill(32'h2000, 8);
    rd_base  = rd_total;
    exp_base = 32'h2000;
    store(BEGIN_A, 32'h2000);
    store(END_A, 32'h2000 + 4 * 8);
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (k < 100 && !(ram_rd === 1'b1 && gold_addr === GOLD_AW'(3)));
    check("midrst/reached_word3", 64'(k < 100), 64'(1));
    rst_b = 1'b0;
    #1;
    check("midrst/outputs_now", all_outs(), 64'(0));
    @(posedge clk);
    #1;
    check("midrst/outputs_edge", all_outs(), 64'(0));
    @(negedge clk);
    rst_b = 1'b1;
    run_walk("rerun", 32'h2000, 8, 0);

    // Randomized regions, random corruption, random non-multiple-of-4 tails.
    for (int t = 0; t < 6; t++) begin
      do_reset();
      n = $urandom_range(1, 20);
      b = 32'h1000 + 4 * $urandom_range(0, 1023);
      fill(b, n);
      for (int c = 0; c < int'($urandom_range(0, 3)); c++)
        corrupt(b, $urandom_range(0, n - 1));
      run_walk($sformatf("rand%0d", t), b, n, $urandom_range(0, 3));
    end

`ifndef SIG_CHECK_TIMEOUT_EN
    // Exactly golden-depth region is allowed; last word corrupted.
    do_reset();
    fill(32'h2000, 1024);
    corrupt(32'h2000, 1023);
    run_walk("full1024", 32'h2000, 1024, 0);
    check("full1024/idx_const", 64'(fail_idx), 64'(1023));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1);
  end

endmodule
